// File: rtl/trdb_pkg.sv
// Shared trace-encoder types: packet formats, sync subformats, tick-source modes
// and the resync scheduler state encoding.
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'b00,
        F_DIFF_DELTA = 2'b01,
        F_ADDR_ONLY  = 2'b10,
        F_SYNC       = 2'b11
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'b00,
        SF_TRAP    = 2'b01,
        SF_CONTEXT = 2'b10,
        SF_SUPPORT = 2'b11
    } trdb_f_sync_subformat_e;

    localparam bit CYCLE_MODE  = 1'b0;
    localparam bit PACKET_MODE = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COUNTING = 2'b01,
        PENDING  = 2'b10
    } trdb_resync_state_e;

    localparam int unsigned RESYNC_CNT_W = 16;

endpackage

// File: rtl/trdb_resync_counter.sv
// Resync scheduler: counts cycles or packets since the last sync packet and
// requests a format-3 sync from the emitter once the threshold is reached.
module trdb_resync_counter
    import trdb_pkg::*;
#(
    parameter bit          MODE  = CYCLE_MODE,
    parameter int unsigned CNT_W = RESYNC_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [CNT_W-1:0]       threshold_i,
    input  logic                   packet_valid_i,
    input  trdb_format_e           packet_format_i,
    input  trdb_f_sync_subformat_e packet_subformat_i,
    output logic                   resync_o,
    output logic                   overdue_o,
    output logic [CNT_W-1:0]       count_o
);

    trdb_resync_state_e state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               resync_q, resync_d;
    logic               overdue_q, overdue_d;

    logic               sync_seen;
    logic               tick;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;

    always_comb begin
        sync_seen = packet_valid_i && (packet_format_i == F_SYNC) &&
                    ((packet_subformat_i == SF_START) || (packet_subformat_i == SF_TRAP));
        // Context/support sync packets are ordinary traffic for packet counting.
        tick      = (MODE == CYCLE_MODE) ? enable_i : (packet_valid_i && !sync_seen);
        cnt_inc   = count_q + CNT_W'(1);
        hit       = (cnt_inc >= threshold_i);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        resync_d  = resync_q;
        overdue_d = overdue_q;
        if (!enable_i || (threshold_i == '0)) begin
            state_d   = IDLE;
            count_d   = '0;
            resync_d  = 1'b0;
            overdue_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNTING;
                    count_d = '0;
                end
                COUNTING: begin
                    if (sync_seen) begin
                        count_d = '0;
                    end else if (tick) begin
                        if (hit) begin
                            state_d  = PENDING;
                            count_d  = '0;
                            resync_d = 1'b1;
                        end else begin
                            count_d = cnt_inc;
                        end
                    end
                end
                PENDING: begin
                    if (sync_seen) begin
                        state_d   = COUNTING;
                        count_d   = '0;
                        resync_d  = 1'b0;
                        overdue_d = 1'b0;
                    end else if (tick) begin
                        // Saturate so a long-unserviced request never wraps the count.
                        if (hit) begin
                            overdue_d = 1'b1;
                            count_d   = threshold_i - CNT_W'(1);
                        end else begin
                            count_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    count_d   = '0;
                    resync_d  = 1'b0;
                    overdue_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            resync_q  <= 1'b0;
            overdue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            resync_q  <= resync_d;
            overdue_q <= overdue_d;
        end
    end

    assign resync_o  = resync_q;
    assign overdue_o = overdue_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_trdb_resync_counter.sv
// Scoreboard bench for trdb_resync_counter: one instance per tick mode sharing
// the same stimulus; each scenario pushes hand-derived expectations per cycle.
module tb_trdb_resync_counter;
    import trdb_pkg::*;

    localparam int W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic [W-1:0]           thr;
    logic                   pv;
    trdb_format_e           fmt;
    trdb_f_sync_subformat_e sf;
    logic                   r_c, ov_c, r_p, ov_p;
    logic [W-1:0]           cnt_c, cnt_p;

    always #5 clk = ~clk;

    trdb_resync_counter #(.MODE(CYCLE_MODE), .CNT_W(W)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .threshold_i(thr),
        .packet_valid_i(pv), .packet_format_i(fmt), .packet_subformat_i(sf),
        .resync_o(r_c), .overdue_o(ov_c), .count_o(cnt_c));

    trdb_resync_counter #(.MODE(PACKET_MODE), .CNT_W(W)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .threshold_i(thr),
        .packet_valid_i(pv), .packet_format_i(fmt), .packet_subformat_i(sf),
        .resync_o(r_p), .overdue_o(ov_p), .count_o(cnt_p));

    typedef struct {
        logic                   rst_n;
        logic                   en;
        logic [W-1:0]           thr;
        logic                   pv;
        trdb_format_e           fmt;
        trdb_f_sync_subformat_e sf;
        logic                   r;
        logic                   ov;
        logic [W-1:0]           cnt;
    } row_t;

    row_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic row_t mk(logic rn, logic e, int t, logic p, trdb_format_e f,
                                trdb_f_sync_subformat_e s, logic r, logic o, int c);
        row_t x;
        x.rst_n = rn; x.en = e; x.thr = W'(t); x.pv = p; x.fmt = f; x.sf = s;
        x.r = r; x.ov = o; x.cnt = W'(c);
        return x;
    endfunction

    task automatic drive(input row_t x);
        rst_n = x.rst_n; en = x.en; thr = x.thr; pv = x.pv; fmt = x.fmt; sf = x.sf;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        row_t e;
        drive(mk(0, 0, 0, 0, F_OPT_EXT, SF_START, 0, 0, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total += 3;
        if (r_c !== e.r || r_p !== e.r)   begin bad++; $display("FAIL reset_resync got %b/%b want %b", r_c, r_p, e.r); end
        if (ov_c !== e.ov || ov_p !== e.ov) begin bad++; $display("FAIL reset_overdue got %b/%b want %b", ov_c, ov_p, e.ov); end
        if (cnt_c !== e.cnt || cnt_p !== e.cnt) begin bad++; $display("FAIL reset_count got %0d/%0d want %0d", cnt_c, cnt_p, e.cnt); end
    endtask

    // Cycle mode: request after 4 ticks, then serviced by a start sync.
    task automatic test_cycle_basic();
        row_t s[$];
        row_t e;
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 0));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 1));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 2));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 3));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 1, 0, 0));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 1, 0, 1));
        s.push_back(mk(1, 1, 4, 1, F_SYNC,    SF_START, 0, 0, 0));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total += 3;
            if (r_c !== e.r)     begin bad++; $display("FAIL cycle_basic[%0d] resync got %b want %b", i, r_c, e.r); end
            if (ov_c !== e.ov)   begin bad++; $display("FAIL cycle_basic[%0d] overdue got %b want %b", i, ov_c, e.ov); end
            if (cnt_c !== e.cnt) begin bad++; $display("FAIL cycle_basic[%0d] count got %0d want %0d", i, cnt_c, e.cnt); end
        end
    endtask

    // Packet mode: support-sync counts as a packet, overdue saturates, trap-sync clears.
    task automatic test_packet_mode();
        row_t s[$];
        row_t e;
        s.push_back(mk(1, 1, 3, 0, F_OPT_EXT,    SF_START,   0, 0, 0));
        s.push_back(mk(1, 1, 3, 1, F_ADDR_ONLY,  SF_START,   0, 0, 1));
        s.push_back(mk(1, 1, 3, 1, F_SYNC,       SF_SUPPORT, 0, 0, 2));
        s.push_back(mk(1, 1, 3, 1, F_DIFF_DELTA, SF_START,   1, 0, 0));
        s.push_back(mk(1, 1, 3, 0, F_ADDR_ONLY,  SF_START,   1, 0, 0));
        s.push_back(mk(1, 1, 3, 1, F_ADDR_ONLY,  SF_START,   1, 0, 1));
        s.push_back(mk(1, 1, 3, 1, F_ADDR_ONLY,  SF_START,   1, 0, 2));
        s.push_back(mk(1, 1, 3, 1, F_ADDR_ONLY,  SF_START,   1, 1, 2));
        s.push_back(mk(1, 1, 3, 1, F_ADDR_ONLY,  SF_START,   1, 1, 2));
        s.push_back(mk(1, 1, 3, 1, F_SYNC,       SF_TRAP,    0, 0, 0));
        s.push_back(mk(1, 1, 3, 1, F_SYNC,       SF_CONTEXT, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total += 3;
            if (r_p !== e.r)     begin bad++; $display("FAIL packet_mode[%0d] resync got %b want %b", i, r_p, e.r); end
            if (ov_p !== e.ov)   begin bad++; $display("FAIL packet_mode[%0d] overdue got %b want %b", i, ov_p, e.ov); end
            if (cnt_p !== e.cnt) begin bad++; $display("FAIL packet_mode[%0d] count got %0d want %0d", i, cnt_p, e.cnt); end
        end
    endtask

    // Sync arriving on the threshold-reaching tick suppresses the request.
    task automatic test_back_to_back();
        row_t s[$];
        row_t e;
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 0));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 1));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 2));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 3));
        s.push_back(mk(1, 1, 4, 1, F_SYNC,    SF_START, 0, 0, 0));
        s.push_back(mk(1, 1, 4, 0, F_OPT_EXT, SF_START, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total += 3;
            if (r_c !== e.r)     begin bad++; $display("FAIL back_to_back[%0d] resync got %b want %b", i, r_c, e.r); end
            if (ov_c !== e.ov)   begin bad++; $display("FAIL back_to_back[%0d] overdue got %b want %b", i, ov_c, e.ov); end
            if (cnt_c !== e.cnt) begin bad++; $display("FAIL back_to_back[%0d] count got %0d want %0d", i, cnt_c, e.cnt); end
        end
    endtask

    // Lowering the threshold under the current count fires on the next tick.
    task automatic test_threshold_change();
        row_t s[$];
        row_t e;
        s.push_back(mk(1, 1, 10, 0, F_OPT_EXT, SF_START, 0, 0, 0));
        for (int k = 1; k <= 6; k++)
            s.push_back(mk(1, 1, 10, 0, F_OPT_EXT, SF_START, 0, 0, k));
        s.push_back(mk(1, 1, 5, 0, F_OPT_EXT, SF_START, 1, 0, 0));
        s.push_back(mk(1, 1, 5, 0, F_OPT_EXT, SF_START, 1, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total += 3;
            if (r_c !== e.r)     begin bad++; $display("FAIL thr_change[%0d] resync got %b want %b", i, r_c, e.r); end
            if (ov_c !== e.ov)   begin bad++; $display("FAIL thr_change[%0d] overdue got %b want %b", i, ov_c, e.ov); end
            if (cnt_c !== e.cnt) begin bad++; $display("FAIL thr_change[%0d] count got %0d want %0d", i, cnt_c, e.cnt); end
        end
    endtask

    // From overdue: reset, disable and zero threshold each clear everything.
    task automatic test_abort();
        row_t s[$];
        row_t e;
        for (int pass = 0; pass < 3; pass++) begin
            s.push_back(mk(1, 1, 2, 0, F_OPT_EXT,   SF_START, 0, 0, 0));
            s.push_back(mk(1, 1, 2, 1, F_ADDR_ONLY, SF_START, 0, 0, 1));
            s.push_back(mk(1, 1, 2, 1, F_ADDR_ONLY, SF_START, 1, 0, 0));
            s.push_back(mk(1, 1, 2, 1, F_ADDR_ONLY, SF_START, 1, 0, 1));
            s.push_back(mk(1, 1, 2, 1, F_ADDR_ONLY, SF_START, 1, 1, 1));
            if (pass == 0) s.push_back(mk(0, 1, 2, 0, F_OPT_EXT,   SF_START, 0, 0, 0));
            if (pass == 1) s.push_back(mk(1, 0, 2, 1, F_ADDR_ONLY, SF_START, 0, 0, 0));
            if (pass == 2) begin
                s.push_back(mk(1, 1, 0, 1, F_ADDR_ONLY, SF_START, 0, 0, 0));
                s.push_back(mk(1, 1, 0, 1, F_ADDR_ONLY, SF_START, 0, 0, 0));
                s.push_back(mk(1, 1, 0, 1, F_SYNC,      SF_START, 0, 0, 0));
            end
        end
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total += 3;
            if (r_p !== e.r)     begin bad++; $display("FAIL abort[%0d] resync got %b want %b", i, r_p, e.r); end
            if (ov_p !== e.ov)   begin bad++; $display("FAIL abort[%0d] overdue got %b want %b", i, ov_p, e.ov); end
            if (cnt_p !== e.cnt) begin bad++; $display("FAIL abort[%0d] count got %0d want %0d", i, cnt_p, e.cnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; thr = '0; pv = 1'b0; fmt = F_OPT_EXT; sf = SF_START;
        @(posedge clk); #1;
        test_reset();
        test_cycle_basic();
        test_reset();
        test_packet_mode();
        test_reset();
        test_back_to_back();
        test_reset();
        test_threshold_change();
        test_reset();
        test_abort();
        if (exp_q.size() != 0) begin
            bad++; total++;
            $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
